// File: rtl/fei4_cmd_pkg.sv
// Shared FE-I4 command definitions: decoder FSM states, header and field codes.
package fei4_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FIELD2,
        FIELD3,
        FIELD4,
        FIELD5,
        DATA,
        ERR_FLUSH
    } state_t;

    // 5-bit headers
    localparam logic [4:0] HDR_LV1  = 5'b11101;
    localparam logic [4:0] HDR_FAST = 5'b10110;

    // field2 codes following HDR_FAST
    localparam logic [3:0] F2_BCR  = 4'b0001;
    localparam logic [3:0] F2_ECR  = 4'b0010;
    localparam logic [3:0] F2_CAL  = 4'b0100;
    localparam logic [3:0] F2_SLOW = 4'b1000;

    // field3 slow-command codes
    localparam logic [3:0] F3_RD_REG  = 4'b0001;
    localparam logic [3:0] F3_WR_REG  = 4'b0010;
    localparam logic [3:0] F3_WR_FE   = 4'b0100;
    localparam logic [3:0] F3_GRST    = 4'b1000;
    localparam logic [3:0] F3_GPULSE  = 4'b1001;
    localparam logic [3:0] F3_RUNMODE = 4'b1010;

    function automatic logic f3_legal(input logic [3:0] code);
        case (code)
            F3_RD_REG, F3_WR_REG, F3_WR_FE,
            F3_GRST, F3_GPULSE, F3_RUNMODE: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fei4_cmd_decoder.sv
// FE-I4 serial command decoder: fast commands (LV1/BCR/ECR/CAL) and addressed slow commands.
module fei4_cmd_decoder
    import fei4_cmd_pkg::*;
#(
    parameter int unsigned FE_WORDS = 42
) (
    input  logic        CMD_CLK,
    input  logic        RESET,
    input  logic        CMD_DATA,
    input  logic [2:0]  CHIP_ID,
    output logic        LV1,
    output logic        BCR,
    output logic        ECR,
    output logic        CAL,
    output logic        SLOW_VALID,
    output logic [3:0]  SLOW_CMD,
    output logic [5:0]  SLOW_ADDR,
    output logic [15:0] SLOW_DATA,
    output logic [15:0] FE_WORD,
    output logic        FE_WORD_VALID,
    output logic        ERR,
    output logic        BUSY
);

    localparam int unsigned WCW = (FE_WORDS > 1) ? $clog2(FE_WORDS) : 1;
    localparam logic [9:0]  FE_LAST_BIT = 10'(FE_WORDS * 16 - 1);

    state_t          state_q, state_d;
    logic [9:0]      cnt_q, cnt_d;
    logic [15:0]     sr_q, sr_d;
    logic [3:0]      cmd_q, cmd_d;
    logic            hit_q, hit_d;
    logic [5:0]      f5_q, f5_d;
    logic [WCW-1:0]  word_q, word_d;

    logic            lv1_q, lv1_d, bcr_q, bcr_d, ecr_q, ecr_d, cal_q, cal_d;
    logic            err_q, err_d, slow_valid_q, slow_valid_d, fe_valid_q, fe_valid_d;
    logic [3:0]      slow_cmd_q, slow_cmd_d;
    logic [5:0]      slow_addr_q, slow_addr_d;
    logic [15:0]     slow_data_q, slow_data_d, fe_word_q, fe_word_d;

    logic [15:0]     shifted;
    assign shifted = {sr_q[14:0], CMD_DATA};

    // Next-state, field capture and strobe generation; cnt_q holds bits left in the state minus one.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q - 10'd1;
        sr_d         = shifted;
        cmd_d        = cmd_q;
        hit_d        = hit_q;
        f5_d         = f5_q;
        word_d       = word_q;
        lv1_d        = 1'b0;
        bcr_d        = 1'b0;
        ecr_d        = 1'b0;
        cal_d        = 1'b0;
        err_d        = 1'b0;
        slow_valid_d = 1'b0;
        fe_valid_d   = 1'b0;
        slow_cmd_d   = slow_cmd_q;
        slow_addr_d  = slow_addr_q;
        slow_data_d  = slow_data_q;
        fe_word_d    = fe_word_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (CMD_DATA) begin
                    state_d = HEADER;
                    cnt_d   = 10'd3;
                end
            end
            HEADER: if (cnt_q == '0) begin
                if (shifted[4:0] == HDR_LV1) begin
                    lv1_d   = 1'b1;
                    state_d = IDLE;
                end else if (shifted[4:0] == HDR_FAST) begin
                    state_d = FIELD2;
                    cnt_d   = 10'd3;
                end else begin
                    err_d   = 1'b1;
                    state_d = ERR_FLUSH;
                    cnt_d   = '0;
                end
            end
            FIELD2: if (cnt_q == '0) begin
                state_d = IDLE;
                cnt_d   = '0;
                case (shifted[3:0])
                    F2_BCR:  bcr_d = 1'b1;
                    F2_ECR:  ecr_d = 1'b1;
                    F2_CAL:  cal_d = 1'b1;
                    F2_SLOW: begin
                        state_d = FIELD3;
                        cnt_d   = 10'd3;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = ERR_FLUSH;
                    end
                endcase
            end
            FIELD3: if (cnt_q == '0) begin
                if (f3_legal(shifted[3:0])) begin
                    cmd_d   = shifted[3:0];
                    state_d = FIELD4;
                    cnt_d   = 10'd3;
                end else begin
                    err_d   = 1'b1;
                    state_d = ERR_FLUSH;
                    cnt_d   = '0;
                end
            end
            FIELD4: if (cnt_q == '0) begin
                hit_d   = shifted[3] | (shifted[2:0] == CHIP_ID);
                state_d = FIELD5;
                cnt_d   = 10'd5;
            end
            FIELD5: if (cnt_q == '0) begin
                f5_d   = shifted[5:0];
                word_d = '0;
                if (cmd_q == F3_WR_REG) begin
                    state_d = DATA;
                    cnt_d   = 10'd15;
                end else if (cmd_q == F3_WR_FE) begin
                    state_d = DATA;
                    cnt_d   = FE_LAST_BIT;
                end else begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    slow_valid_d = hit_q;
                    if (hit_q) begin
                        slow_cmd_d  = cmd_q;
                        slow_addr_d = shifted[5:0];
                    end
                end
            end
            DATA: begin
                // Payload length is a multiple of 16, so word ends align with cnt_q[3:0] == 0.
                if (cmd_q == F3_WR_FE && cnt_q[3:0] == 4'd0) begin
                    fe_valid_d = hit_q;
                    if (hit_q) fe_word_d = shifted;
                    word_d = (word_q == WCW'(FE_WORDS - 1)) ? '0 : word_q + 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    slow_valid_d = hit_q;
                    if (hit_q) begin
                        slow_cmd_d  = cmd_q;
                        slow_addr_d = f5_q;
                        if (cmd_q == F3_WR_REG) slow_data_d = shifted;
                    end
                end
            end
            ERR_FLUSH: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge CMD_CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            cmd_q        <= '0;
            hit_q        <= 1'b0;
            f5_q         <= '0;
            word_q       <= '0;
            lv1_q        <= 1'b0;
            bcr_q        <= 1'b0;
            ecr_q        <= 1'b0;
            cal_q        <= 1'b0;
            err_q        <= 1'b0;
            slow_valid_q <= 1'b0;
            fe_valid_q   <= 1'b0;
            slow_cmd_q   <= '0;
            slow_addr_q  <= '0;
            slow_data_q  <= '0;
            fe_word_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            cmd_q        <= cmd_d;
            hit_q        <= hit_d;
            f5_q         <= f5_d;
            word_q       <= word_d;
            lv1_q        <= lv1_d;
            bcr_q        <= bcr_d;
            ecr_q        <= ecr_d;
            cal_q        <= cal_d;
            err_q        <= err_d;
            slow_valid_q <= slow_valid_d;
            fe_valid_q   <= fe_valid_d;
            slow_cmd_q   <= slow_cmd_d;
            slow_addr_q  <= slow_addr_d;
            slow_data_q  <= slow_data_d;
            fe_word_q    <= fe_word_d;
        end
    end

    assign LV1           = lv1_q;
    assign BCR           = bcr_q;
    assign ECR           = ecr_q;
    assign CAL           = cal_q;
    assign ERR           = err_q;
    assign SLOW_VALID    = slow_valid_q;
    assign FE_WORD_VALID = fe_valid_q;
    assign SLOW_CMD      = slow_cmd_q;
    assign SLOW_ADDR     = slow_addr_q;
    assign SLOW_DATA     = slow_data_q;
    assign FE_WORD       = fe_word_q;
    assign BUSY          = (state_q != IDLE);

endmodule

// File: tb/tb_fei4_cmd_decoder.sv
// Scoreboard bench for fei4_cmd_decoder: stimulus queues expected strobes, a monitor checks them.
module tb_fei4_cmd_decoder;

    logic        CMD_CLK = 1'b0;
    logic        RESET;
    logic        CMD_DATA;
    logic [2:0]  CHIP_ID = 3'd4;
    logic        LV1, BCR, ECR, CAL, SLOW_VALID, FE_WORD_VALID, ERR, BUSY;
    logic [3:0]  SLOW_CMD;
    logic [5:0]  SLOW_ADDR;
    logic [15:0] SLOW_DATA, FE_WORD;

    fei4_cmd_decoder #(.FE_WORDS(42)) dut (
        .CMD_CLK(CMD_CLK), .RESET(RESET), .CMD_DATA(CMD_DATA), .CHIP_ID(CHIP_ID),
        .LV1(LV1), .BCR(BCR), .ECR(ECR), .CAL(CAL),
        .SLOW_VALID(SLOW_VALID), .SLOW_CMD(SLOW_CMD), .SLOW_ADDR(SLOW_ADDR),
        .SLOW_DATA(SLOW_DATA), .FE_WORD(FE_WORD), .FE_WORD_VALID(FE_WORD_VALID),
        .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CMD_CLK = ~CMD_CLK;

    int unsigned cyc = 0;
    always @(posedge CMD_CLK) cyc <= cyc + 1;

    // strobe vector order: {LV1, BCR, ECR, CAL, ERR, SLOW_VALID, FE_WORD_VALID}
    localparam logic [6:0] S_LV1 = 7'b1000000;
    localparam logic [6:0] S_BCR = 7'b0100000;
    localparam logic [6:0] S_ECR = 7'b0010000;
    localparam logic [6:0] S_CAL = 7'b0001000;
    localparam logic [6:0] S_ERR = 7'b0000100;
    localparam logic [6:0] S_SV  = 7'b0000010;
    localparam logic [6:0] S_FE  = 7'b0000001;

    typedef struct {
        int unsigned cyc;
        logic [6:0]  strb;
        logic [3:0]  cmd;
        logic [5:0]  addr;
        logic [15:0] data;
        logic [15:0] fe;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        compared++;
        if (got !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    // Expected strobe appears on the negedge after the posedge that samples the last driven bit.
    task automatic push(input logic [6:0] strb, input logic [3:0] cmd, input logic [5:0] addr,
                        input logic [15:0] data, input logic [15:0] fe);
        exp_t e;
        e.cyc = cyc + 1; e.strb = strb; e.cmd = cmd; e.addr = addr; e.data = data; e.fe = fe;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge CMD_CLK);
            CMD_DATA = v[i];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CMD_CLK);
            CMD_DATA = 1'b0;
        end
    endtask

    // Monitor: any strobe pops one expectation and compares timing and fields.
    always @(negedge CMD_CLK) begin
        logic [6:0] strb;
        exp_t e;
        strb = {LV1, BCR, ECR, CAL, ERR, SLOW_VALID, FE_WORD_VALID};
        if (strb != 7'd0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {25'd0, strb}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("strobe_set", {25'd0, strb}, {25'd0, e.strb});
                if (e.strb[1]) begin
                    chk("slow_cmd", {28'd0, SLOW_CMD}, {28'd0, e.cmd});
                    chk("slow_addr", {26'd0, SLOW_ADDR}, {26'd0, e.addr});
                    if (e.cmd == 4'b0010) chk("slow_data", {16'd0, SLOW_DATA}, {16'd0, e.data});
                end
                if (e.strb[0]) chk("fe_word", {16'd0, FE_WORD}, {16'd0, e.fe});
            end
        end
    end

    localparam logic [8:0] SLOW_PFX = 9'b10110_1000;

    initial begin
        int span, highs;
        RESET = 1'b1;
        CMD_DATA = 1'b0;
        repeat (3) @(negedge CMD_CLK);
        chk("reset_strobes", {25'd0, LV1, BCR, ECR, CAL, ERR, SLOW_VALID, FE_WORD_VALID}, 32'd0);
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        chk("reset_fields", {6'd0, SLOW_CMD, SLOW_ADDR, SLOW_DATA}, 32'd0);
        RESET = 1'b0;
        idle(2);

        // LV1
        send(64'b11101, 5);  push(S_LV1, 0, 0, 0, 0);  idle(3);
        // fast commands
        send(64'b10110_0010, 9); push(S_ECR, 0, 0, 0, 0); idle(2);
        send(64'b10110_0001, 9); push(S_BCR, 0, 0, 0, 0); idle(2);
        send(64'b10110_0100, 9); push(S_CAL, 0, 0, 0, 0); idle(2);
        // illegal field2: ERR, then one flush cycle, then IDLE
        send(64'b10110_0011, 9); push(S_ERR, 0, 0, 0, 0);
        @(negedge CMD_CLK); CMD_DATA = 1'b0;
        chk("flush_busy", {31'd0, BUSY}, 32'd1);
        @(negedge CMD_CLK); CMD_DATA = 1'b0;
        chk("idle_after_err", {31'd0, BUSY}, 32'd0);
        idle(2);
        // illegal header
        send(64'b11000, 5); push(S_ERR, 0, 0, 0, 0); idle(3);
        // illegal field3
        send({SLOW_PFX, 4'b0011}, 13); push(S_ERR, 0, 0, 0, 0); idle(3);

        // WR_REG addressed to chip 4, addr 27, data 0x8000
        send({SLOW_PFX, 4'b0010, 4'b0100, 6'd27, 16'h8000}, 39);
        push(S_SV, 4'b0010, 6'd27, 16'h8000, 0);
        idle(2);

        // Same WR_REG to chip 3: no strobe, BUSY spans 39 cycles from the first bit
        begin
            logic [63:0] v;
            v = {25'd0, SLOW_PFX, 4'b0010, 4'b0011, 6'd27, 16'h1234};
            span = 0; highs = 0;
            for (int i = 38; i >= 0; i--) begin
                @(negedge CMD_CLK);
                if (i != 38 && BUSY) highs++;
                CMD_DATA = v[i];
                span++;
            end
            for (int k = 0; k < 16; k++) begin
                @(negedge CMD_CLK);
                CMD_DATA = 1'b0;
                if (!BUSY) break;
                span++;
            end
            chk("busy_span", span, 32'd39);
            chk("busy_contiguous", highs, 32'd38);
            chk("hold_slow_data", {16'd0, SLOW_DATA}, 32'h8000);
            chk("hold_slow_addr", {26'd0, SLOW_ADDR}, 32'd27);
        end
        idle(2);

        // WR_REG whose payload contains an LV1 pattern
        send({SLOW_PFX, 4'b0010, 4'b0100, 6'd1, 16'h3A00}, 39);
        push(S_SV, 4'b0010, 6'd1, 16'h3A00, 0);
        idle(2);

        // RD_REG and GPULSE (broadcast), no payload
        send({SLOW_PFX, 4'b0001, 4'b0100, 6'd3}, 23);  push(S_SV, 4'b0001, 6'd3, 0, 0);
        send({SLOW_PFX, 4'b1001, 4'b1000, 6'd10}, 23); push(S_SV, 4'b1001, 6'd10, 0, 0);
        idle(2);

        // WR_FE broadcast, all-ones payload
        send({SLOW_PFX, 4'b0100, 4'b1011, 6'd5}, 23);
        for (int w = 0; w < 42; w++) begin
            send(64'hFFFF, 16);
            if (w == 41) push(S_FE | S_SV, 4'b0100, 6'd5, 0, 16'hFFFF);
            else         push(S_FE, 0, 0, 0, 16'hFFFF);
        end
        idle(2);

        // LV1 immediately followed by RUNMODE 111000
        send(64'b11101, 5); push(S_LV1, 0, 0, 0, 0);
        send({SLOW_PFX, 4'b1010, 4'b0100, 6'b111000}, 23);
        push(S_SV, 4'b1010, 6'h38, 0, 0);
        idle(2);

        // Reset at payload bit 10 of a WR_REG
        send({SLOW_PFX, 4'b0010, 4'b0100, 6'd27, 10'b1010101010}, 33);
        @(negedge CMD_CLK); RESET = 1'b1; CMD_DATA = 1'b1;
        @(negedge CMD_CLK);
        @(negedge CMD_CLK); RESET = 1'b0; CMD_DATA = 1'b0;
        @(negedge CMD_CLK);
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_cleared", {6'd0, SLOW_CMD, SLOW_ADDR, SLOW_DATA}, 32'd0);
        send(64'b11101, 5); push(S_LV1, 0, 0, 0, 0);
        idle(5);

        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("missing_strobe", 32'd0, {25'd0, e.strb});
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fei4_cmd_decoder.md
FEI4_CMD_DECODER -- requirements
Module: fei4_cmd_decoder

Interface
REQ-001 SHALL have parameter FE_WORDS, default 42: number of 16-bit payload words in a WR_FE command (672 bits).
REQ-002 SHALL have port CMD_CLK, input, 1 bit: the single clock; the serial command bit is sampled on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port CMD_DATA, input, 1 bit: serial command stream, MSB first, idle low.
REQ-005 SHALL have port CHIP_ID, input, 3 bits: local chip address.
REQ-006 SHALL have ports LV1, BCR, ECR and CAL, outputs, 1 bit each: single-cycle fast-command strobes.
REQ-007 SHALL have port SLOW_VALID, output, 1 bit: single-cycle strobe marking a completed, addressed slow command.
REQ-008 SHALL have port SLOW_CMD, output, 4 bits: the field3 code (RD_REG 0001, WR_REG 0010, WR_FE 0100, GRST 1000, GPULSE 1001, RUNMODE 1010).
REQ-009 SHALL have port SLOW_ADDR, output, 6 bits: field5 (register address, pulse width or run-mode code).
REQ-010 SHALL have port SLOW_DATA, output, 16 bits: WR_REG data.
REQ-011 SHALL have ports FE_WORD, output, 16 bits, and FE_WORD_VALID, output, 1 bit: streamed WR_FE payload word and its strobe.
REQ-012 SHALL have port ERR, output, 1 bit: single-cycle strobe on an illegal code.
REQ-013 SHALL have port BUSY, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL treat 0 bits in IDLE as idle and start a command on the first 1 bit, which is the header MSB.
REQ-015 SHALL, for header 5'b11101, pulse LV1 one cycle after the 5th header bit is sampled.
REQ-016 SHALL, for header 5'b10110, read a 4-bit field2: 0001 gives BCR, 0010 gives ECR, 0100 gives CAL, each strobed one cycle after the last field2 bit; 1000 selects slow-command decoding; any other value gives ERR.
REQ-017 SHALL, for any other 5-bit header, pulse ERR and return to IDLE.
REQ-018 SHALL decode slow commands as field3 (4 bits), then field4 (chip ID, 4 bits), then field5 (6 bits), then a payload: 16 bits for WR_REG, FE_WORDS×16 bits for WR_FE, none for all other codes.
REQ-019 SHALL treat a command as addressed when field4[3] is 1 (broadcast) or field4[2:0] equals CHIP_ID.
REQ-020 SHALL pulse ERR and consume no further bits after field3 when field3 is not one of the six legal codes.
REQ-021 SHALL pulse SLOW_VALID one cycle after the last bit of the command.
REQ-022 SHALL hold SLOW_CMD, SLOW_ADDR and SLOW_DATA stable from the SLOW_VALID cycle until the next SLOW_VALID.
REQ-023 SHALL pulse FE_WORD_VALID one cycle after each 16th WR_FE payload bit, giving FE_WORDS pulses per command; SLOW_VALID SHALL follow in the same cycle as the last FE_WORD_VALID.
REQ-024 SHALL run an unaddressed slow command to completion while keeping SLOW_VALID and FE_WORD_VALID low.
REQ-025 SHALL treat bits arriving inside a command as payload; LV1 patterns there SHALL NOT strobe LV1.
REQ-026 SHALL allow back-to-back commands: a 1 in the cycle following the last bit starts a new header with no idle gap required.
REQ-027 SHALL use FSM states IDLE, HEADER, FIELD2, FIELD3, FIELD4, FIELD5, DATA and ERR_FLUSH, where ERR_FLUSH lasts one cycle and then goes to IDLE.
REQ-028 SHALL use one 10-bit bit counter that reloads on every state change; payload words SHALL be counted modulo FE_WORDS.

Reset
REQ-029 SHALL, while RESET is high, force the FSM to IDLE, drive all strobes and BUSY to 0, and clear SLOW_CMD, SLOW_ADDR, SLOW_DATA and FE_WORD to 0.
REQ-030 SHALL abort an in-progress command on reset without emitting any strobe for it; decoding SHALL restart on the first 1 after RESET falls.

Structure
REQ-031 SHALL take header codes, field2 and field3 codes, and the state enum from a shared package fei4_cmd_pkg, which the command encoder also uses.
REQ-032 SHALL contain no sub-module: one FSM, one shift register and counters.

Verification
REQ-033 SHALL cover: bits 11101 -> LV1 high exactly 1 cycle, 1 cycle after the 5th bit; no other strobe.
REQ-034 SHALL cover: 10110_0010 -> ECR pulse; 10110_0011 -> ERR pulse, FSM back in IDLE 2 cycles later.
REQ-035 SHALL cover: WR_REG, chip 0100 (matches CHIP_ID=4), addr 27, data 0x8000 -> SLOW_VALID with SLOW_CMD=0010, SLOW_ADDR=27, SLOW_DATA=0x8000; the same with chip 0011 -> no SLOW_VALID, BUSY for 39 cycles.
REQ-036 SHALL cover: WR_FE broadcast (1xxx) with payload all ones -> 42 FE_WORD_VALID pulses of 0xFFFF, the last coincident with SLOW_VALID.
REQ-037 SHALL cover: LV1 immediately followed by RUNMODE 111000 -> LV1 then SLOW_VALID with SLOW_CMD=1010, SLOW_ADDR=0x38.
REQ-038 SHALL cover: RESET asserted at payload bit 10 of WR_REG -> no strobes, IDLE; a following LV1 is decoded correctly.
